// File: rtl/bus_arb_rr.sv
// Round-robin arbiter sharing one valid/ready slave bus among NUM_MASTERS requesters,
// with a watchdog that completes stalled transfers using a fixed error word.
module bus_arb_rr #(
    parameter int unsigned NUM_MASTERS  = 4,
    parameter int unsigned TIMEOUT      = 255,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_MASTERS-1:0]    m_valid,
    output logic [NUM_MASTERS-1:0]    m_ready,
    input  logic [NUM_MASTERS*32-1:0] m_addr,
    input  logic [NUM_MASTERS*32-1:0] m_wdata,
    input  logic [NUM_MASTERS*4-1:0]  m_wstrb,
    output logic [NUM_MASTERS*32-1:0] m_rdata,
    output logic                      s_valid,
    input  logic                      s_ready,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wdata,
    output logic [3:0]                s_wstrb,
    input  logic [31:0]               s_rdata,
    output logic [NUM_MASTERS-1:0]    grant,
    output logic                      timeout_err
);

    localparam int unsigned IW = $clog2(NUM_MASTERS);
    localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] gidx_q, gidx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] gidx_next;
    logic          req_g;
    logic          limit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // First requester at or after ptr, wrapping modulo NUM_MASTERS.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            int idx;
            idx = int'(ptr_q) + i;
            if (idx >= int'(NUM_MASTERS)) idx = idx - int'(NUM_MASTERS);
            if (!pick_found && m_valid[IW'(idx)]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(idx);
            end
        end
    end

    assign gidx_next = (gidx_q == IW'(NUM_MASTERS - 1)) ? '0 : gidx_q + 1'b1;
    assign req_g     = m_valid[gidx_q];
    assign limit     = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

    always_comb begin
        state_d     = state_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        s_valid     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        grant       = '0;
        m_ready     = '0;
        m_rdata     = '0;
        timeout_err = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // s_valid drops at the watchdog limit independent of s_ready, so there is
                // no combinational s_ready -> s_valid path; a late s_ready still completes.
                s_valid        = req_g && !limit;
                s_addr         = m_addr[32*int'(gidx_q) +: 32];
                s_wdata        = m_wdata[32*int'(gidx_q) +: 32];
                s_wstrb        = m_wstrb[4*int'(gidx_q) +: 4];
                grant[gidx_q]  = 1'b1;
                if (!req_g) begin
                    state_d = StIdle;
                    ptr_d   = gidx_next;
                end else if (s_ready) begin
                    m_ready[gidx_q]                 = 1'b1;
                    m_rdata[32*int'(gidx_q) +: 32]  = s_rdata;
                    state_d                         = StIdle;
                    ptr_d                           = gidx_next;
                end else if (limit) begin
                    m_ready[gidx_q]                 = 1'b1;
                    m_rdata[32*int'(gidx_q) +: 32]  = TIMEOUT_DATA;
                    timeout_err                     = 1'b1;
                    state_d                         = StIdle;
                    ptr_d                           = gidx_next;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: doc/bus_arb_rr.md
# bus_arb_rr

Round-robin arbiter that shares one valid/ready memory bus between `NUM_MASTERS` requesters: core instruction port, core data port, and further masters such as a DMA or debug unit. It sits between the masters and the single slave bus at the top level. It grants one master at a time, holds the grant until the slave completes the transfer, and rotates priority after every completion. A watchdog completes a stalled transfer with a fixed error word so a dead slave cannot hang the system.

## Interface
- `NUM_MASTERS`, 4: number of requesters, 2..8.
- `TIMEOUT`, 255: BUSY cycles without `s_ready` before forced completion; 0 disables the watchdog.
- `TIMEOUT_DATA`, 32'hDEAD_BEEF: read data returned on forced completion.

One clock; reset is asynchronous and active-low.
- `clk` in 1: clock, all state on rising edge.
- `resetn` in 1: asynchronous active-low reset.
- `m_valid` in N: per-master request, held until its `m_ready`.
- `m_ready` out N: per-master completion pulse, one cycle.
- `m_addr` in N*32: master i at bits [32i+31:32i].
- `m_wdata` in N*32: write data, same packing.
- `m_wstrb` in N*4: byte strobes; 0 means read.
- `m_rdata` out N*32: read data, valid for master i while `m_ready[i]`=1.
- `s_valid` out 1: slave request.
- `s_ready` in 1: slave completion.
- `s_addr` out 32: slave address.
- `s_wdata` out 32: slave write data.
- `s_wstrb` out 4: slave byte strobes.
- `s_rdata` in 32: slave read data.
- `grant` out N: one-hot current owner, 0 when idle.
- `timeout_err` out 1: one-cycle pulse on forced completion.

## Operation
- States: IDLE, BUSY. Registers: `state`, `gidx` (granted index), `ptr` (priority start index), `cnt` (watchdog, width $clog2(TIMEOUT+1), min 1).
- IDLE:
  - If any `m_valid` is high, select the first index `ptr`, `ptr`+1, … (mod N) with `m_valid` high.
  - Load `gidx`, clear `cnt`, and move to BUSY.
  - If no master is requesting, stay in IDLE.
- BUSY, combinational outputs:
  - `s_valid` = `m_valid[gidx]`.
  - `s_addr`, `s_wdata`, `s_wstrb` = slice `gidx` of the master buses.
  - `grant` = one-hot(`gidx`).
- BUSY, slave completes (`s_ready`=1 while `s_valid`=1):
  - `m_ready[gidx]`=1 and `m_rdata[gidx]`=`s_rdata` in the same cycle.
  - Next state IDLE; `ptr` ← (`gidx`+1) mod N.
- BUSY, watchdog:
  - When TIMEOUT≠0 and `cnt`==TIMEOUT without `s_ready`, force completion.
  - Forced completion: `m_ready[gidx]`=1, `m_rdata[gidx]`=`TIMEOUT_DATA`, `timeout_err`=1, `s_valid` forced 0 that cycle, then IDLE with `ptr` advanced.
  - Otherwise `cnt` increments each BUSY cycle.
- Watchdog priority: if `s_ready` arrives in the same cycle the watchdog fires, `s_ready` wins. Normal completion, no error.
- Master withdraws `m_valid[gidx]` in BUSY (protocol violation):
  - Arbiter returns to IDLE next cycle with `ptr` advanced.
  - No `m_ready`, no error.
- `s_ready` in IDLE is ignored.
- Outputs outside BUSY:
  - `s_addr`, `s_wdata`, `s_wstrb`, `grant` = 0.
  - Every `m_rdata` slice not currently completing = 0.
- Reset values: `state`=IDLE, `ptr`=0, `gidx`=0, `cnt`=0. All outputs are 0.
- Reset mid-transfer aborts immediately: `s_valid` drops asynchronously and no `m_ready` is issued.

## Timing
- Request seen high at edge t in IDLE: `s_valid` is high during cycle t+1.
- Slave ready at cycle k: master `m_ready` is also at cycle k, with zero added completion latency.
- Completion is always followed by one IDLE cycle, so back-to-back throughput is at most one transfer per 2 + slave-latency cycles.
- No combinational path from `s_ready` to `s_valid` or `s_addr`. Paths from `s_ready` to `m_ready` and from `s_rdata` to `m_rdata` are combinational.
- Forced completion occurs in the (TIMEOUT+1)-th BUSY cycle.
- Fairness: a continuously requesting master waits at most N−1 other transfers.

## Test plan
- **Single read:** after reset, `m_valid[1]`=1, `m_addr[1]`=0x100, `wstrb`=0; slave responds after 2 cycles with 0x1234_5678.
  - `s_valid` rises 1 cycle after the request, `s_addr`=0x100, `grant`=4'b0010.
  - `m_ready[1]` pulses exactly once, with `m_rdata[1]`=0x1234_5678.
- **Round-robin:** all 4 masters request continuously with a 0-wait slave.
  - Grant order is 0, 1, 2, 3, 0, … with exactly one IDLE cycle between transfers.
- **Write pass-through:** master 2 writes 0xCAFE_F00D to 0x40 with `wstrb`=4'b0011.
  - The slave sees identical `s_addr`, `s_wdata`, `s_wstrb`; `m_ready[2]` pulses once.
- **Timeout:** TIMEOUT=4, slave never asserts ready.
  - In the 5th BUSY cycle, `m_ready[0]`=1, `m_rdata[0]`=0xDEAD_BEEF, `timeout_err`=1 for one cycle.
  - The next pending master is granted afterwards.
- **Watchdog boundary:** `s_ready` arrives in the same cycle as `cnt`==TIMEOUT.
  - Normal data is returned, `timeout_err` stays 0.
- **Reset mid-transfer:** assert `resetn`=0 while BUSY.
  - All outputs go 0 asynchronously.
  - After release, arbitration restarts at master 0 (`ptr`=0).
